// File: rtl/transmissor_malha.sv
// Serialises a snapshot of the occupancy grid as a byte stream: 0xA5 header, packed cells, optional XOR checksum.
// Define TRANSMISSOR_CHECKSUM_EN to append the checksum byte before the end-of-frame pulse.
module transmissor_malha #(
   parameter int unsigned TamanhoMalha = 8
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] malha,
   input  logic                                         operacaoFinalizada,
   output logic [7:0]                                   dadoSaida,
   output logic                                         dadoValido,
   input  logic                                         dadoPronto,
   output logic                                         ocupado,
   output logic                                         quadroFinalizado
);

   localparam int unsigned COLS  = TamanhoMalha / 4;
   localparam int unsigned TOTAL = TamanhoMalha * TamanhoMalha / 4;
   localparam int unsigned CW    = $clog2(TOTAL);
   localparam int unsigned XW    = $clog2(TamanhoMalha);
   localparam int unsigned KW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [7:0]  CABEC = 8'hA5;

   typedef enum logic [2:0] {
      OCIOSO,
      CABECALHO,
      DADOS,
      CHECKSUM,
      FIM
   } estado_t;

   estado_t                                      estado;
   logic                                         op_q;
   logic [CW-1:0]                                cnt;
   logic [KW-1:0]                                col;
   logic [XW-1:0]                                lin;
   logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] snap;
   logic [7:0]                                   byte_c;
   logic                                         borda;
   logic                                         transf;
`ifdef TRANSMISSOR_CHECKSUM_EN
   logic [7:0]                                   chk;
`endif

   assign borda  = operacaoFinalizada & ~op_q;
   assign transf = dadoValido & dadoPronto;

   // Byte at the read pointer: four consecutive-x cells of row lin, lowest x in the low bits.
   assign byte_c = {snap[XW'({col, 2'd3})][lin], snap[XW'({col, 2'd2})][lin],
                    snap[XW'({col, 2'd1})][lin], snap[XW'({col, 2'd0})][lin]};

   // Snapshot is captured only when a frame is launched; its contents are not reset.
   always_ff @(posedge clock) begin
      if (reset && estado == OCIOSO && borda) begin
         snap <= malha;
      end
   end

   // Frame FSM; col/lin always point at the next data byte to load into dadoSaida.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado           <= OCIOSO;
         op_q             <= 1'b0;
         cnt              <= '0;
         col              <= '0;
         lin              <= '0;
         dadoSaida        <= 8'h00;
         dadoValido       <= 1'b0;
         ocupado          <= 1'b0;
         quadroFinalizado <= 1'b0;
`ifdef TRANSMISSOR_CHECKSUM_EN
         chk              <= 8'h00;
`endif
      end else begin
         op_q             <= operacaoFinalizada;
         quadroFinalizado <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (borda) begin
                  estado     <= CABECALHO;
                  dadoSaida  <= CABEC;
                  dadoValido <= 1'b1;
                  ocupado    <= 1'b1;
                  cnt        <= '0;
                  col        <= '0;
                  lin        <= '0;
`ifdef TRANSMISSOR_CHECKSUM_EN
                  chk        <= 8'h00;
`endif
               end
            end
            CABECALHO: begin
               if (transf) begin
                  estado    <= DADOS;
                  dadoSaida <= byte_c;
                  if (col == KW'(COLS - 1)) begin
                     col <= '0;
                     lin <= lin + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DADOS: begin
               if (transf) begin
`ifdef TRANSMISSOR_CHECKSUM_EN
                  chk <= chk ^ dadoSaida;
`endif
                  if (cnt == CW'(TOTAL - 1)) begin
`ifdef TRANSMISSOR_CHECKSUM_EN
                     estado    <= CHECKSUM;
                     dadoSaida <= chk ^ dadoSaida;
`else
                     estado           <= FIM;
                     dadoSaida        <= 8'h00;
                     dadoValido       <= 1'b0;
                     quadroFinalizado <= 1'b1;
`endif
                  end else begin
                     cnt       <= cnt + 1'b1;
                     dadoSaida <= byte_c;
                     if (col == KW'(COLS - 1)) begin
                        col <= '0;
                        lin <= lin + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
`ifdef TRANSMISSOR_CHECKSUM_EN
            CHECKSUM: begin
               if (transf) begin
                  estado           <= FIM;
                  dadoSaida        <= 8'h00;
                  dadoValido       <= 1'b0;
                  quadroFinalizado <= 1'b1;
               end
            end
`endif
            FIM: begin
               estado  <= OCIOSO;
               ocupado <= 1'b0;
            end
            default: begin
               estado     <= OCIOSO;
               dadoSaida  <= 8'h00;
               dadoValido <= 1'b0;
               ocupado    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmissor_malha.sv
// Self-checking bench for transmissor_malha: random grids and ready patterns against a frame model built from the grid.
// Honours TRANSMISSOR_CHECKSUM_EN the same way the design does.
module tb_transmissor_malha;

   localparam int N      = 8;
   localparam int IW     = $clog2(N);
   localparam int LIMITE = 400;

   logic                       clock = 1'b0;
   logic                       reset;
   logic [N-1:0][N-1:0][1:0]   malha;
   logic                       operacaoFinalizada;
   logic [7:0]                 dadoSaida;
   logic                       dadoValido;
   logic                       dadoPronto;
   logic                       ocupado;
   logic                       quadroFinalizado;

   int         total  = 0;
   int         passou = 0;
   logic [7:0] esperado[$];
   logic [7:0] recebidos[$];
   int         pulsos;
   int         viol;
   int         bolhas;
   int         primeiro;
   logic       esgotado;

   transmissor_malha #(.TamanhoMalha(N)) dut (
      .clock              (clock),
      .reset              (reset),
      .malha              (malha),
      .operacaoFinalizada (operacaoFinalizada),
      .dadoSaida          (dadoSaida),
      .dadoValido         (dadoValido),
      .dadoPronto         (dadoPronto),
      .ocupado            (ocupado),
      .quadroFinalizado   (quadroFinalizado)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected frame from the current grid: header, row-major packed cells, optional XOR of the data bytes.
   task automatic monta_quadro();
      logic [7:0] b;
      esperado = {};
      esperado.push_back(8'hA5);
      for (int y = 0; y < N; y++) begin
         for (int k = 0; k < N / 4; k++) begin
            b = 8'h00;
            for (int i = 0; i < 4; i++) b = b | (8'(malha[IW'(4 * k + i)][IW'(y)]) << (2 * i));
            esperado.push_back(b);
         end
      end
`ifdef TRANSMISSOR_CHECKSUM_EN
      b = 8'h00;
      for (int j = 1; j < esperado.size(); j++) b = b ^ esperado[j];
      esperado.push_back(b);
`endif
   endtask

   task automatic grade_aleatoria();
      for (int x = 0; x < N; x++)
         for (int y = 0; y < N; y++)
            malha[x][y] = 2'($urandom_range(2));
   endtask

   function automatic int primeira_dif();
      if (recebidos.size() != esperado.size()) return -2;
      foreach (esperado[i]) if (recebidos[i] !== esperado[i]) return i;
      return -1;
   endfunction

   function automatic string descreve(int d);
      if (d == -2) return $sformatf("length %0d, required %0d", recebidos.size(), esperado.size());
      return $sformatf("byte %0d = %h, required %h", d, recebidos[d], esperado[d]);
   endfunction

   task automatic dispara();
      operacaoFinalizada = 1'b0;
      @(negedge clock);
      operacaoFinalizada = 1'b1;
   endtask

   // Records every handshaken byte until the cycle after the end-of-frame pulse; tallies protocol violations.
   task automatic coleta(input int segura, input int prob, input int mexe_em);
      logic       pv, pp;
      logic [7:0] pd;
      int         ult;
      recebidos = {};
      pulsos = 0; viol = 0; bolhas = 0; primeiro = -1; esgotado = 1'b1;
      pv = 1'b0; pp = 1'b0; pd = 8'h00; ult = -1;
      for (int c = 0; c < LIMITE; c++) begin
         @(negedge clock);
         if (pv && !pp && (dadoValido !== 1'b1 || dadoSaida !== pd)) viol++;
         if (dadoValido !== 1'b1 && dadoSaida !== 8'h00) viol++;
         if (quadroFinalizado === 1'b1) begin
            pulsos++;
            if (dadoValido !== 1'b0) viol++;
         end else if (pulsos > 0) begin
            if (ocupado !== 1'b0) viol++;
            esgotado = 1'b0;
            break;
         end
         if (mexe_em >= 0 && c == mexe_em) begin
            malha[0][0] = 2'b10;
            operacaoFinalizada = 1'b0;
         end
         if (mexe_em >= 0 && c == mexe_em + 2) operacaoFinalizada = 1'b1;
         dadoPronto = (c < segura) ? 1'b0 : ($urandom_range(99) < prob);
         if (dadoValido === 1'b1 && dadoPronto) begin
            if (prob >= 100 && ult >= 0 && c != ult + 1) bolhas++;
            if (ult < 0) primeiro = c;
            ult = c;
            recebidos.push_back(dadoSaida);
         end
         pv = dadoValido; pp = dadoPronto; pd = dadoSaida;
      end
   endtask

   task automatic test_reset();
      int ativ;
      reset = 1'b0; operacaoFinalizada = 1'b0; dadoPronto = 1'b0; malha = '0;
      repeat (2) @(negedge clock);
      total++;
      if ({dadoValido, ocupado, quadroFinalizado} !== 3'b000)
         $display("FAIL reset_flags: valid/busy/done = %b, required 000", {dadoValido, ocupado, quadroFinalizado});
      else passou++;
      total++;
      if (dadoSaida !== 8'h00) $display("FAIL reset_data: dadoSaida = %h, required 00", dadoSaida);
      else passou++;
      reset = 1'b1;
      ativ = 0;
      repeat (6) begin
         @(negedge clock);
         if (dadoValido !== 1'b0 || ocupado !== 1'b0 || quadroFinalizado !== 1'b0) ativ++;
      end
      total++;
      if (ativ != 0) $display("FAIL idle_after_reset: %0d active cycles, required 0", ativ);
      else passou++;
   endtask

   task automatic test_zeros();
      int d;
      malha = '0;
      monta_quadro();
      dispara();
      coleta(0, 100, -1);
      d = primeira_dif();
      total++;
      if (d != -1) $display("FAIL zeros_frame: %s", descreve(d)); else passou++;
      total++;
      if (pulsos != 1 || esgotado) $display("FAIL zeros_done: pulses %0d timeout %0d, required 1 and 0", pulsos, esgotado);
      else passou++;
      total++;
      if (bolhas != 0 || viol != 0) $display("FAIL zeros_stream: bubbles %0d violations %0d, required 0 and 0", bolhas, viol);
      else passou++;
   endtask

   task automatic test_packing();
      int d;
      malha = '0;
      malha[1][0] = 2'b01;
      malha[3][0] = 2'b10;
      monta_quadro();
      dispara();
      coleta(0, 100, -1);
      total++;
      if (recebidos.size() < 2 || recebidos[1] !== 8'h84)
         $display("FAIL packing_first: first data byte %h (len %0d), required 84", recebidos.size() > 1 ? recebidos[1] : 8'hxx, recebidos.size());
      else passou++;
      d = primeira_dif();
      total++;
      if (d != -1) $display("FAIL packing_frame: %s", descreve(d)); else passou++;
      total++;
      if (pulsos != 1 || viol != 0) $display("FAIL packing_done: pulses %0d violations %0d, required 1 and 0", pulsos, viol);
      else passou++;
   endtask

   task automatic test_backpressure();
      int d;
      grade_aleatoria();
      monta_quadro();
      dispara();
      coleta(3, 100, -1);
      total++;
      if (primeiro != 3 || recebidos.size() == 0 || recebidos[0] !== 8'hA5)
         $display("FAIL bp_header: first transfer at cycle %0d, required 3 with A5", primeiro);
      else passou++;
      total++;
      if (viol != 0) $display("FAIL bp_hold: violations %0d, required 0", viol); else passou++;
      d = primeira_dif();
      total++;
      if (d != -1) $display("FAIL bp_frame: %s", descreve(d)); else passou++;
      total++;
      if (pulsos != 1 || bolhas != 0) $display("FAIL bp_done: pulses %0d bubbles %0d, required 1 and 0", pulsos, bolhas);
      else passou++;
   endtask

   task automatic test_snapshot();
      int d, ativ;
      grade_aleatoria();
      malha[0][0] = 2'b00;
      monta_quadro();
      dispara();
      coleta(0, 100, 4);
      d = primeira_dif();
      total++;
      if (d != -1) $display("FAIL snapshot_frame: %s", descreve(d)); else passou++;
      total++;
      if (pulsos != 1 || viol != 0) $display("FAIL snapshot_done: pulses %0d violations %0d, required 1 and 0", pulsos, viol);
      else passou++;
      ativ = 0;
      repeat (8) begin
         @(negedge clock);
         if (ocupado !== 1'b0 || dadoValido !== 1'b0) ativ++;
      end
      total++;
      if (ativ != 0) $display("FAIL retrigger: %0d active cycles after frame, required 0", ativ); else passou++;
      operacaoFinalizada = 1'b0;
   endtask

   task automatic test_random();
      int d;
      for (int f = 0; f < 5; f++) begin
         grade_aleatoria();
         monta_quadro();
         dispara();
         coleta(0, 60, -1);
         d = primeira_dif();
         total++;
         if (d != -1) $display("FAIL random_frame %0d: %s", f, descreve(d)); else passou++;
         total++;
         if (pulsos != 1 || viol != 0 || esgotado)
            $display("FAIL random_done %0d: pulses %0d violations %0d timeout %0d, required 1 0 0", f, pulsos, viol, esgotado);
         else passou++;
      end
   endtask

   task automatic test_reset_mid();
      int d, qf;
      grade_aleatoria();
      monta_quadro();
      dispara();
      dadoPronto = 1'b1;
      repeat (6) @(negedge clock);
      total++;
      if (dadoValido !== 1'b1 || dadoSaida !== esperado[5])
         $display("FAIL mid_fifth_byte: valid %b data %h, required 1 and %h", dadoValido, dadoSaida, esperado[5]);
      else passou++;
      reset = 1'b0;
      dadoPronto = 1'b0;
      qf = 0;
      @(negedge clock);
      total++;
      if (dadoValido !== 1'b0 || ocupado !== 1'b0)
         $display("FAIL mid_abort: valid %b busy %b, required 0 and 0", dadoValido, ocupado);
      else passou++;
      if (quadroFinalizado !== 1'b0) qf++;
      @(negedge clock);
      if (quadroFinalizado !== 1'b0) qf++;
      total++;
      if (qf != 0) $display("FAIL mid_no_done: %0d done pulses, required 0", qf); else passou++;
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (dadoValido !== 1'b1 || dadoSaida !== 8'hA5)
         $display("FAIL start_after_reset: valid %b data %h, required 1 and a5", dadoValido, dadoSaida);
      else passou++;
      coleta(0, 100, -1);
      d = primeira_dif();
      total++;
      if (d != -1 || pulsos != 1) $display("FAIL after_reset_frame: %s, pulses %0d", d == -1 ? "ok" : descreve(d), pulsos);
      else passou++;
      operacaoFinalizada = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zeros();
      test_packing();
      test_backpressure();
      test_snapshot();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
